slave_port_initiator: RTL and testbench

SLAVE_PORT_INITIATOR -- requirements
Module: slave_port_initiator

---
 rtl/slave_port_pkg.sv | 15 +
 rtl/slave_port_initiator.sv | 158 +++++++++++++++
 tb/tb_slave_port_initiator.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_port_pkg.sv
// Shared definitions for the slave-port initiator: FSM state encoding and default field widths.
package slave_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_SIZE_W = 4;

endpackage

// File: rtl/slave_port_initiator.sv
// Single-outstanding command initiator driving channel 0 of a packed slave-port bus.
// Optional WAIT watchdog enabled by defining SLAVE_PORT_INITIATOR_TIMEOUT_EN.
module slave_port_initiator
    import slave_port_pkg::*;
#(
    parameter int CH      = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SIZE_W  = DEF_SIZE_W,
    parameter int TIMEOUT = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_we,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_wdata,
    input  logic [SIZE_W-1:0]      cmd_size,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [CH-1:0]          S_oe_ram,
    output logic [CH-1:0]          S_we_ram,
    output logic [CH*ADDR_W-1:0]   S_addr_ram,
    output logic [CH*DATA_W-1:0]   S_Wdata_ram,
    output logic [CH*SIZE_W-1:0]   S_data_ram_size,
    input  logic [CH*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [CH-1:0]          Sout_DataRdy
);

    state_t              state_q;
    state_t              state_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [SIZE_W-1:0]   size_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                oe0;
    logic                we0;
    logic                done;

    // Only channel 0 completes; upper channels are never listened to.
    assign done = Sout_DataRdy[0];

    logic unused_inputs;
    assign unused_inputs = ^{Sout_DataRdy, Sout_Rdata_ram};

`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_hit;
    logic             err_q;

    // Fires on the last WAIT cycle of the budget, so RESP follows exactly TIMEOUT cycles after entering WAIT.
    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    assign rsp_err     = err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_WAIT && state_d == ST_WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_q <= '0;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = done ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                if (done) begin
                    state_d = ST_RESP;
`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d = ST_RESP;
`endif
                end
            end
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        oe0       = 1'b0;
        we0       = 1'b0;
        case (state_q)
            ST_IDLE:  cmd_ready = 1'b1;
            ST_ISSUE: begin
                oe0 = ~we_q;
                we0 = we_q;
            end
            ST_RESP:  rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    // Command latch and response capture; fields stay held across WAIT and RESP.
    always_ff @(posedge clock) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rdata_q <= '0;
`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            if (state_q == ST_IDLE && cmd_valid) begin
                we_q    <= cmd_we;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                size_q  <= cmd_size;
            end
            if ((state_q == ST_ISSUE || state_q == ST_WAIT) && done) begin
                rdata_q <= we_q ? '0 : Sout_Rdata_ram[DATA_W-1:0];
`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
                err_q   <= 1'b0;
            end else if (state_q == ST_WAIT && timeout_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
`endif
            end
        end
    end

    assign rsp_rdata = rdata_q;

    // Channel 0 occupies the LSBs; zero-extension ties channels 1..CH-1 to 0.
    assign S_oe_ram        = CH'(oe0);
    assign S_we_ram        = CH'(we0);
    assign S_addr_ram      = (CH*ADDR_W)'(addr_q);
    assign S_Wdata_ram     = (CH*DATA_W)'(wdata_q);
    assign S_data_ram_size = (CH*SIZE_W)'(size_q);

endmodule

// File: tb/tb_slave_port_initiator.sv
// Directed bench for slave_port_initiator; the watchdog scenario runs when SLAVE_PORT_INITIATOR_TIMEOUT_EN is defined.
module tb_slave_port_initiator;

    localparam int CH      = 2;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int SIZE_W  = 4;
    localparam int TIMEOUT = 4;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic                 cmd_we = 1'b0;
    logic [ADDR_W-1:0]    cmd_addr = '0;
    logic [DATA_W-1:0]    cmd_wdata = '0;
    logic [SIZE_W-1:0]    cmd_size = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [DATA_W-1:0]    rsp_rdata;
    logic                 rsp_err;
    logic [CH-1:0]        S_oe_ram;
    logic [CH-1:0]        S_we_ram;
    logic [CH*ADDR_W-1:0] S_addr_ram;
    logic [CH*DATA_W-1:0] S_Wdata_ram;
    logic [CH*SIZE_W-1:0] S_data_ram_size;
    logic [CH*DATA_W-1:0] Sout_Rdata_ram = '0;
    logic [CH-1:0]        Sout_DataRdy = '0;

    int n_checks = 0;
    int n_fail   = 0;

    slave_port_initiator #(
        .CH(CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input logic [SIZE_W-1:0] sz);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_size  = sz;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_strobes", {S_oe_ram, S_we_ram}, 0);
        check("rst_fields", {S_addr_ram, S_Wdata_ram, S_data_ram_size}, 0);
        check("rst_rsp", {rsp_err, rsp_rdata}, 0);

        // Read, DataRdy two cycles after the strobe
        offer(1'b0, 7'h05, 8'h00, 4'd8);
        check("rd_issue_oe", S_oe_ram, 2'b01);
        check("rd_issue_we", S_we_ram, 2'b00);
        check("rd_issue_addr", S_addr_ram, 14'h0005);
        check("rd_issue_cmd_ready", cmd_ready, 0);
        step();
        check("rd_wait_oe", S_oe_ram, 2'b00);
        check("rd_wait_addr", S_addr_ram, 14'h0005);
        step();
        Sout_DataRdy   = 2'b01;
        Sout_Rdata_ram = 16'h003C;
        check("rd_wait2_rsp_valid", rsp_valid, 0);
        step();
        Sout_DataRdy = 2'b00;
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 8'h3C);
        check("rd_rsp_err", rsp_err, 0);
        release_rsp();
        check("rd_done_valid", rsp_valid, 0);
        check("rd_done_ready", cmd_ready, 1);

        // Write
        offer(1'b1, 7'h7F, 8'hA5, 4'd8);
        check("wr_issue_we", S_we_ram, 2'b01);
        check("wr_issue_oe", S_oe_ram, 2'b00);
        check("wr_issue_addr", S_addr_ram, 14'h007F);
        check("wr_issue_wdata", S_Wdata_ram, 16'h00A5);
        check("wr_issue_size", S_data_ram_size, 8'h08);
        step();
        check("wr_wait_we", S_we_ram, 2'b00);
        check("wr_wait_wdata", S_Wdata_ram, 16'h00A5);
        Sout_DataRdy   = 2'b01;
        Sout_Rdata_ram = 16'hFFFF;
        step();
        Sout_DataRdy = 2'b00;
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_rdata", rsp_rdata, 0);
        release_rsp();

        // Completion in ISSUE, then backpressure
        offer(1'b0, 7'h12, 8'h00, 4'd4);
        check("sc_issue_oe", S_oe_ram, 2'b01);
        Sout_DataRdy   = 2'b01;
        Sout_Rdata_ram = 16'h0077;
        step();
        Sout_DataRdy = 2'b00;
        check("sc_rsp_valid", rsp_valid, 1);
        check("sc_rsp_rdata", rsp_rdata, 8'h77);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, 8'h77);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_strobes", {S_oe_ram, S_we_ram}, 0);
        end
        release_rsp();
        check("bp_done_valid", rsp_valid, 0);
        check("bp_done_ready", cmd_ready, 1);

        // Spurious DataRdy in IDLE, foreign DataRdy[1] in WAIT
        Sout_DataRdy   = 2'b11;
        Sout_Rdata_ram = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            check("sp_idle_valid", rsp_valid, 0);
            check("sp_idle_ready", cmd_ready, 1);
            check("sp_idle_strobes", {S_oe_ram, S_we_ram}, 0);
        end
        Sout_DataRdy = 2'b00;
        offer(1'b0, 7'h21, 8'h00, 4'd8);
        check("fg_issue_oe", S_oe_ram, 2'b01);
        step();
        Sout_DataRdy   = 2'b10;
        Sout_Rdata_ram = 16'h5500;
        for (int i = 0; i < 2; i++) begin
            step();
            check("fg_wait_valid", rsp_valid, 0);
            check("fg_wait_ready", cmd_ready, 0);
            check("fg_wait_oe", S_oe_ram, 2'b00);
        end
        Sout_DataRdy   = 2'b01;
        Sout_Rdata_ram = 16'h5511;
        step();
        Sout_DataRdy = 2'b00;
        check("fg_rsp_valid", rsp_valid, 1);
        check("fg_rsp_rdata", rsp_rdata, 8'h11);
        release_rsp();

        // Reset while in WAIT
        offer(1'b0, 7'h30, 8'h00, 4'd8);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rw_cmd_ready", cmd_ready, 1);
        check("rw_rsp_valid", rsp_valid, 0);
        check("rw_addr", S_addr_ram, 0);
        Sout_DataRdy   = 2'b01;
        Sout_Rdata_ram = 16'h00EE;
        step();
        Sout_DataRdy = 2'b00;
        check("rw_idle_valid", rsp_valid, 0);
        check("rw_idle_oe", S_oe_ram, 2'b00);
        offer(1'b0, 7'h31, 8'h00, 4'd8);
        check("rw_issue_oe", S_oe_ram, 2'b01);
        check("rw_issue_addr", S_addr_ram, 14'h0031);
        step();
        Sout_DataRdy   = 2'b01;
        Sout_Rdata_ram = 16'h009A;
        step();
        Sout_DataRdy = 2'b00;
        check("rw_rsp_valid", rsp_valid, 1);
        check("rw_rsp_rdata", rsp_rdata, 8'h9A);
        release_rsp();

        // No DataRdy while in WAIT
        offer(1'b0, 7'h40, 8'h00, 4'd8);
        step();
`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            step();
            check("to_wait_valid", rsp_valid, 0);
        end
        step();
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        release_rsp();
        check("to_done_ready", cmd_ready, 1);
`else
        for (int i = 0; i < 10; i++) begin
            step();
            check("nt_wait_valid", rsp_valid, 0);
            check("nt_wait_err", rsp_err, 0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("nt_after_rst_ready", cmd_ready, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
